// File: rtl/prio_req_encoder_if.sv
// Output handshake bundle of prio_req_encoder: selected index with valid/ready.
// The encoder drives through the master modport; the consumer uses slave.
interface prio_req_encoder_if #(
  parameter int N = 8
) ();
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/prio_req_encoder.sv
// prio_req_encoder: sticky request capture with a registered valid/ready
// grant port and a saturating counter of coalesced (repeated) requests.
// Optional build macro: PRIO_ENC_ROUND_ROBIN_EN selects rotating priority
// instead of fixed highest-index-wins priority.
module prio_req_encoder #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_i,
  prio_req_encoder_if.master  out_if,
  output logic [N-1:0]        pend_o,
  output logic [7:0]          coal_cnt,
  input  logic                coal_clr
);
  localparam int W  = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int SW = CW + 9;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   out_idx_q, out_idx_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [7:0]     coal_q, coal_d;
  logic           hs_s;
  logic [N-1:0]   clr_s;
  logic [N-1:0]   rem_s;
  logic [N-1:0]   coal_bits_s;
  logic [CW-1:0]  coal_num_s;
  logic [SW-1:0]  coal_sum_s;
  logic [W-1:0]   pick_idle_s;
  logic [W-1:0]   pick_hs_s;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] o;
    o = '0;
    for (int i = 0; i < N; i++) begin
      if (W'(i) == idx) begin
        o[i] = 1'b1;
      end else begin
        o[i] = 1'b0;
      end
    end
    return o;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Rotating priority: search p, p-1, ..., wrapping from 0 to N-1.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] res;
    logic         found;
    int           j;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) - i;
      if (j < 0) begin
        j = j + N;
      end else begin
        j = j;
      end
      if (!found && v[j]) begin
        res   = W'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // Pointer moves just below the granted index on every handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (hs_s) begin
      if (out_idx_q == '0) begin
        ptr_d = W'(N - 1);
      end else begin
        ptr_d = out_idx_q - W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Rotating-priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign pick_idle_s = sel(pend_q, ptr_q);
  assign pick_hs_s   = sel(rem_s, ptr_d);
`else
  // Fixed priority: highest set index wins.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        res = W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_idle_s = sel(pend_q);
  assign pick_hs_s   = sel(rem_s);
`endif

  assign hs_s        = (state_q == S_HOLD) && out_if.out_ready;
  assign clr_s       = hs_s ? onehot(out_idx_q) : '0;
  // Remaining work after this handshake; same-cycle requests join next cycle.
  assign rem_s       = pend_q & ~clr_s;
  assign coal_bits_s = req_i & pend_q & ~clr_s;
  assign coal_num_s  = popcount(coal_bits_s);
  assign coal_sum_s  = SW'(coal_q) + SW'(coal_num_s);

  // Pending set wins over clear; coalesce counter saturates, clear dominates.
  always_comb begin
    pend_d = (pend_q & ~clr_s) | req_i;
    coal_d = coal_q;
    if (coal_clr) begin
      coal_d = 8'd0;
    end else if (coal_sum_s > SW'(8'hFF)) begin
      coal_d = 8'hFF;
    end else begin
      coal_d = coal_sum_s[7:0];
    end
  end

  // Pending and coalesce-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      coal_q <= 8'd0;
    end else begin
      pend_q <= pend_d;
      coal_q <= coal_d;
    end
  end

  // Grant FSM state and held index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
    end
  end

  // Grant FSM next state: load on pending work, chain grants on handshake.
  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d   = S_HOLD;
          out_idx_d = pick_idle_s;
        end else begin
          state_d   = S_IDLE;
          out_idx_d = '0;
        end
      end
      S_HOLD: begin
        if (hs_s && (rem_s != '0)) begin
          state_d   = S_HOLD;
          out_idx_d = pick_hs_s;
        end else if (hs_s) begin
          state_d   = S_IDLE;
          out_idx_d = '0;
        end else begin
          state_d   = S_HOLD;
          out_idx_d = out_idx_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        out_idx_d = '0;
      end
    endcase
  end

  // Grant FSM outputs, taken straight from registers.
  always_comb begin
    out_if.out_valid = (state_q == S_HOLD);
    out_if.out_idx   = out_idx_q;
  end

  assign pend_o   = pend_q;
  assign coal_cnt = coal_q;
endmodule
